// File: rtl/hazard_controller.sv
// Pipeline hazard controller: EX forwarding selects, load-use and multi-cycle stalls, branch flushes.
// Latency: forwarding, stall and flush outputs are combinational; a multi-cycle op holds E for MC_LATENCY cycles.
// Backpressure: StallF/StallD/StallE freeze upstream stages and FlushM bubbles M while an op is held in E.
//
// Ports:
//   clk, reset           core clock; synchronous active-high reset
//   Rs1D/Rs2D            source registers of the instruction in D (load-use check)
//   Rs1E/Rs2E/RdE        source and destination registers of the instruction in E
//   RdM/RdW, RegWrite*   destination and write enable of the M and W instructions (forwarding)
//   LoadE, MultiCycleE   E instruction is a load or a multi-cycle (mul/div) op
//   PCSrcE               taken branch/jump resolved in E
//   ForwardAE/BE         00 RD1E/RD2E, 01 ResultW, 10 ALUResultM
//   Stall*/Flush*        pipeline register hold and clear controls
//   MulStart/ExDone      multi-cycle unit start pulse and result-valid pulse
//   StallCount           saturating count of cycles spent with StallF=1
module hazard_controller #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        LoadE,
    input  logic        MultiCycleE,
    input  logic        PCSrcE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        MulStart,
    output logic        ExDone,
    output logic [31:0] StallCount
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lw_stall;
    logic             mc_stall;
    logic             mul_start;
    logic             ex_done;

    // M holds the younger result, so it wins over W.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
            return 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        mc_stall  = 1'b0;
        mul_start = 1'b0;
        ex_done   = 1'b0;
        case (state)
            IDLE: begin
                if (MultiCycleE) begin
                    mc_stall  = 1'b1;
                    mul_start = 1'b1;
                end
            end
            BUSY: begin
                // MultiCycleE is deliberately ignored here: the same op is still in E.
                if (cnt != '0) mc_stall = 1'b1;
                else           ex_done  = 1'b1;
            end
            default: ;
        endcase

        // A load flagged as multi-cycle is illegal; the multi-cycle path takes precedence.
        lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !MultiCycleE;

        if (reset) begin
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushM    = 1'b1;
            MulStart  = 1'b0;
            ExDone    = 1'b0;
        end else begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
            StallF    = lw_stall | mc_stall;
            StallD    = lw_stall | mc_stall;
            StallE    = mc_stall;
            FlushD    = PCSrcE & ~mc_stall;
            FlushE    = (PCSrcE | lw_stall) & ~mc_stall;
            FlushM    = mc_stall;
            MulStart  = mul_start;
            ExDone    = ex_done;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            StallCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MultiCycleE) begin
                        // One IDLE cycle plus MC_LATENCY-1 BUSY cycles gives MC_LATENCY in E.
                        cnt   <= CNT_W'(MC_LATENCY - 2);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) cnt   <= cnt - 1'b1;
                    else           state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (StallF && (StallCount != 32'hFFFF_FFFF))
                StallCount <= StallCount + 32'd1;
        end
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard/sequencing controller for the 5-stage RV32 core; drives the execute stage's forwarding selects and the F/D/E/M stall/flush controls.
- Combinational forwarding and load-use detection, plus a counter FSM that holds a multi-cycle execute op (M-extension mul/div) in E for MC_LATENCY cycles while bubbling M.
- Also provides a saturating stall-cycle performance counter.

Parameters:
MC_LATENCY, 4, total cycles a multi-cycle op occupies E; legal range 2..16.
CNT_W, 4, width of the internal occupancy counter; must hold MC_LATENCY-2.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-high reset
Rs1D  input  5  rs1 of instruction in D
Rs2D  input  5  rs2 of instruction in D
Rs1E  input  5  rs1 of instruction in E
Rs2E  input  5  rs2 of instruction in E
RdE  input  5  rd of instruction in E
RdM  input  5  rd of instruction in M
RdW  input  5  rd of instruction in W
RegWriteM  input  1  M instruction writes the register file
RegWriteW  input  1  W instruction writes the register file
LoadE  input  1  E instruction is a load
MultiCycleE  input  1  E instruction is a multi-cycle op
PCSrcE  input  1  taken branch/jump resolved in E
ForwardAE  output  2  SrcA select: 00 RD1E, 01 ResultW, 10 ALUResultM
ForwardBE  output  2  SrcB select, same encoding
StallF  output  1  hold PC
StallD  output  1  hold IF/ID register
StallE  output  1  hold ID/EX register
FlushD  output  1  clear IF/ID register
FlushE  output  1  clear ID/EX register
FlushM  output  1  insert bubble into EX/MEM register
MulStart  output  1  one-cycle pulse: multi-cycle unit starts
ExDone  output  1  one-cycle pulse: multi-cycle result valid, op leaves E
StallCount  output  32  saturating count of cycles with StallF=1

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Forwarding (comb): ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. M has priority over W. ForwardBE is the same using Rs2E.
- lwStall = LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D) & ~MultiCycleE.
- FSM states: IDLE, BUSY. Counter cnt is CNT_W bits.
- IDLE & MultiCycleE:
  - mcStall=1, MulStart=1.
  - Next edge: cnt<=MC_LATENCY-2, state<=BUSY.
- BUSY & cnt!=0: mcStall=1; next edge cnt<=cnt-1.
- BUSY & cnt==0:
  - mcStall=0, ExDone=1; op advances to M this edge.
  - Next edge: state<=IDLE.
- E occupancy is exactly MC_LATENCY cycles: 1 IDLE cycle plus MC_LATENCY-1 BUSY cycles.
- Outputs:
  - StallF = StallD = lwStall | mcStall.
  - StallE = mcStall.
  - FlushM = mcStall.
  - FlushD = PCSrcE & ~mcStall.
  - FlushE = (PCSrcE | lwStall) & ~mcStall.
- MultiCycleE is not re-sampled in BUSY. The same op stays in E, so no re-trigger occurs.
- In the BUSY cnt==0 cycle a following multi-cycle op is not yet in E. It enters E next cycle, and the FSM, now IDLE, starts it.
- LoadE & MultiCycleE together is illegal; MultiCycleE wins and lwStall is masked.
- PCSrcE while mcStall=1 is ignored. Branches are never multi-cycle; the verification engineer asserts PCSrcE & mcStall never occurs.
- StallCount increments on each edge where StallF=1 and saturates at 0xFFFF_FFFF.
- Reset (sampled at edge): state<=IDLE, cnt<=0, StallCount<=0.
- While reset=1, outputs are forced regardless of state:
  - Stall*=0, ForwardAE/BE=00, MulStart=0, ExDone=0.
  - FlushD=FlushE=FlushM=1.
- Reset during BUSY aborts the op: no ExDone, IDLE on the next edge.

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; drop RegWriteM -> 01; RdM=RdW=0 -> 00.
- LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0, StallCount +1; RdE=0 -> no stall.
- MC_LATENCY=4, MultiCycleE=1 held 4 cycles -> MulStart in cycle 0; StallF/D/E=FlushM=1 in cycles 0-2; ExDone=1, stalls 0 in cycle 3; StallCount +3.
- PCSrcE=1, IDLE -> FlushD=FlushE=1, no stall; PCSrcE with LoadE hazard -> FlushE=1, StallF=1.
- reset=1 asserted in BUSY at cnt=1 -> Flush*=1, no ExDone; IDLE after; a new MultiCycleE op restarts the full 4-cycle sequence.
- Back-to-back multi-cycle ops, MC_LATENCY=2 -> stall pattern 1,0,1,0; ExDone in cycles 1 and 3.
